// File: rtl/pll_lock_sequencer.sv
// Bring-up sequencer for the processor clock domain: filters the PLL lock flag,
// gates the core reset on a stable lock window and issues a programmable clock-enable strobe.
module pll_lock_sequencer #(
  parameter int STABLE_CYCLES = 1024,
  parameter int LOCK_FILTER   = 4,
  parameter int DIV_W         = 4,
  parameter int DIV_DEFAULT   = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pll_lock,
  input  logic             div_req,
  input  logic [DIV_W-1:0] div_val,
  output logic             div_ack,
  output logic             core_rst,
  output logic             clk_en,
  output logic [2:0]       state_o,
  output logic [7:0]       lock_lost_cnt
);

  localparam int STAB_W = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
  localparam int UNL_W  = $clog2(LOCK_FILTER + 1);

  localparam logic [STAB_W-1:0] STAB_LAST = STAB_W'(STABLE_CYCLES - 1);
  localparam logic [UNL_W-1:0]  UNL_LAST  = UNL_W'(LOCK_FILTER - 1);

  typedef enum logic [2:0] {
    S_RESET = 3'd0,
    S_WAIT  = 3'd1,
    S_STAB  = 3'd2,
    S_RUN   = 3'd3,
    S_LOST  = 3'd4
  } state_e;

  state_e            state, state_nxt;
  logic [1:0]        sync_ff;
  logic              lock_s;
  logic [STAB_W-1:0] stab_cnt, stab_nxt;
  logic [UNL_W-1:0]  unl_cnt, unl_nxt;
  logic [DIV_W-1:0]  div_cur, div_cnt, cnt_nxt;
  logic              ack_d;
  logic              req_eff;
  logic              apply;

  assign lock_s  = sync_ff[1];
  assign state_o = state;

  // NOTE: every signal assigned in always_comb gets a default on entry; a path
  // that leaves one unassigned would infer a latch.
  always_comb begin
    state_nxt = state;
    stab_nxt  = '0;
    unl_nxt   = '0;
    cnt_nxt   = '0;
    unique case (state)
      S_RESET: state_nxt = S_WAIT;
      S_WAIT: begin
        if (lock_s) state_nxt = S_STAB;
      end
      S_STAB: begin
        if (!lock_s) begin
          state_nxt = S_WAIT;
        end else if (stab_cnt == STAB_LAST) begin
          state_nxt = S_RUN;
        end else begin
          stab_nxt = stab_cnt + STAB_W'(1);
        end
      end
      S_RUN: begin
        if (!lock_s) begin
          if (unl_cnt == UNL_LAST) state_nxt = S_LOST;
          else                     unl_nxt   = unl_cnt + UNL_W'(1);
        end
      end
      S_LOST: state_nxt = S_WAIT;
      default: state_nxt = S_RESET;
    endcase

    // Count only while staying in RUN; entry into RUN always starts at a strobe.
    if (state == S_RUN && state_nxt == S_RUN)
      cnt_nxt = (div_cnt >= div_cur) ? '0 : div_cnt + DIV_W'(1);

    // The requester holds div_req through the ack cycle and the one after it.
    req_eff = div_req && !div_ack && !ack_d;
    // A change only lands on a strobe boundary, so no period is ever truncated.
    apply   = req_eff && (state_nxt != S_RUN || cnt_nxt == '0);
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_RESET;
      sync_ff       <= '0;
      stab_cnt      <= '0;
      unl_cnt       <= '0;
      div_cnt       <= '0;
      div_cur       <= DIV_W'(DIV_DEFAULT);
      div_ack       <= 1'b0;
      ack_d         <= 1'b0;
      core_rst      <= 1'b1;
      clk_en        <= 1'b0;
      lock_lost_cnt <= '0;
    end else begin
      sync_ff  <= {sync_ff[0], pll_lock};
      state    <= state_nxt;
      stab_cnt <= stab_nxt;
      unl_cnt  <= unl_nxt;
      div_cnt  <= cnt_nxt;
      div_ack  <= apply;
      ack_d    <= div_ack;
      core_rst <= (state_nxt != S_RUN);
      clk_en   <= (state_nxt == S_RUN) && (cnt_nxt == '0);
      if (apply) div_cur <= div_val;
      if (state == S_LOST && lock_lost_cnt != 8'hFF)
        lock_lost_cnt <= lock_lost_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Bench for pll_lock_sequencer: directed bring-up, glitch, loss and divider
// scenarios followed by random lock/request traffic, all against a phase-level model.
module tb_pll_lock_sequencer;

  localparam int STABLE_CYCLES = 16;
  localparam int LOCK_FILTER   = 4;
  localparam int DIV_W         = 4;
  localparam int DIV_DEFAULT   = 0;

  localparam int PH_BOOT = 0;
  localparam int PH_HUNT = 1;
  localparam int PH_RUN  = 2;
  localparam int PH_LOST = 3;

  logic             clk = 1'b0;
  logic             rst;
  logic             pll_lock;
  logic             div_req;
  logic [DIV_W-1:0] div_val;
  logic             div_ack;
  logic             core_rst;
  logic             clk_en;
  logic [2:0]       state_o;
  logic [7:0]       lock_lost_cnt;

  pll_lock_sequencer #(
    .STABLE_CYCLES(STABLE_CYCLES),
    .LOCK_FILTER  (LOCK_FILTER),
    .DIV_W        (DIV_W),
    .DIV_DEFAULT  (DIV_DEFAULT)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .pll_lock     (pll_lock),
    .div_req      (div_req),
    .div_val      (div_val),
    .div_ack      (div_ack),
    .core_rst     (core_rst),
    .clk_en       (clk_en),
    .state_o      (state_o),
    .lock_lost_cnt(lock_lost_cnt)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Phase-level model: WAIT and STAB collapse into one hunt phase measured by the
  // length of the current run of good synchronised lock samples.
  bit sync_q[$];
  int m_phase, m_good, m_bad, m_left, m_cur, m_lost;
  bit m_ack, m_ack_d, e_clk_en, e_core_rst;

  function automatic int exp_state();
    case (m_phase)
      PH_BOOT: return 0;
      PH_HUNT: return (m_good == 0) ? 1 : 2;
      PH_RUN:  return 3;
      default: return 4;
    endcase
  endfunction

  task automatic model_edge();
    bit lock_s, was_run, now_run, strobe, take, ack_recent;
    if (rst) begin
      m_phase = PH_BOOT; sync_q = '{1'b0, 1'b0};
      m_good = 0; m_bad = 0; m_left = 0; m_cur = DIV_DEFAULT; m_lost = 0;
      m_ack = 0; m_ack_d = 0; e_clk_en = 0; e_core_rst = 1;
      return;
    end
    lock_s = sync_q.pop_front();
    sync_q.push_back(pll_lock);
    was_run    = (m_phase == PH_RUN);
    ack_recent = m_ack || m_ack_d;
    case (m_phase)
      PH_BOOT: begin m_phase = PH_HUNT; m_good = 0; end
      PH_HUNT: begin
        if (lock_s) begin
          m_good++;
          if (m_good == STABLE_CYCLES + 1) begin m_phase = PH_RUN; m_bad = 0; end
        end else m_good = 0;
      end
      PH_RUN: begin
        if (lock_s) m_bad = 0;
        else begin
          m_bad++;
          if (m_bad == LOCK_FILTER) m_phase = PH_LOST;
        end
      end
      default: begin
        if (m_lost < 255) m_lost++;
        m_phase = PH_HUNT; m_good = 0;
      end
    endcase
    now_run = (m_phase == PH_RUN);
    strobe  = now_run && (!was_run || m_left == 0);
    take    = div_req && !ack_recent && (!now_run || strobe);
    m_ack_d = m_ack;
    m_ack   = take;
    if (take) m_cur = int'(div_val);
    if (now_run) m_left = strobe ? m_cur : m_left - 1;
    e_clk_en   = strobe;
    e_core_rst = !now_run;
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check("state",    32'(state_o),       32'(exp_state()));
    check("core_rst", 32'(core_rst),      32'(e_core_rst));
    check("clk_en",   32'(clk_en),        32'(e_clk_en));
    check("div_ack",  32'(div_ack),       32'(m_ack));
    check("lost_cnt", 32'(lock_lost_cnt), 32'(m_lost));
    if (m_ack) div_req = 1'b0;
  endtask

  task automatic wait_run();
    for (int i = 0; i < 200 && state_o != 3'd3; i++) step();
    check("wait_run", 32'(state_o), 32'd3);
  endtask

  task automatic do_reset(input bit lock_v);
    rst = 1'b1; pll_lock = lock_v; div_req = 1'b0;
    repeat (2) step();
    rst = 1'b0;
  endtask

  initial begin
    int n, stab_run, acks, seg_left;
    bit saw_wait, early_run, stayed, saw_lost, lock_v;
    logic [5:0] pat;

    // Bring-up with lock present from the start.
    rst = 1'b1; pll_lock = 1'b1; div_req = 1'b0; div_val = '0;
    repeat (3) step();
    check("rst_state", 32'(state_o), 32'd0);
    check("rst_core",  32'(core_rst), 32'd1);
    rst = 1'b0;
    n = 1;
    while (state_o != 3'd3 && n < 100) begin step(); n++; end
    check("t1_run_cycle", 32'(n), 32'(2 + 1 + 1 + STABLE_CYCLES));
    check("t1_core_rst",  32'(core_rst), 32'd0);
    check("t1_first_en",  32'(clk_en), 32'd1);

    // One-cycle lock drop partway through the stability window.
    do_reset(1'b1);
    for (int i = 0; i < 50 && m_good != 11; i++) step();
    pll_lock = 1'b0; step(); pll_lock = 1'b1;
    saw_wait = 0; stab_run = 0; early_run = 0;
    for (int i = 0; i < 100 && state_o != 3'd3; i++) begin
      step();
      if (state_o == 3'd1) saw_wait = 1;
      if (state_o == 3'd2 && saw_wait) stab_run++;
      if (state_o != 3'd3 && !core_rst) early_run = 1;
    end
    check("t2_back_to_wait", 32'(saw_wait), 32'd1);
    check("t2_full_window",  32'(stab_run), 32'(STABLE_CYCLES));
    check("t2_core_rst_held", 32'(early_run), 32'd0);

    // Unlock shorter than the filter is ignored; a longer one is a loss event.
    wait_run();
    stayed = 1;
    pll_lock = 1'b0; repeat (3) begin step(); if (state_o != 3'd3) stayed = 0; end
    pll_lock = 1'b1; repeat (8) begin step(); if (state_o != 3'd3) stayed = 0; end
    check("t3_glitch_ignored", 32'(stayed), 32'd1);
    saw_lost = 0; saw_wait = 0;
    pll_lock = 1'b0; repeat (5) begin step(); if (state_o == 3'd4 && core_rst) saw_lost = 1; end
    pll_lock = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      if (state_o == 3'd4 && core_rst) saw_lost = 1;
      if (saw_lost && state_o == 3'd1) saw_wait = 1;
    end
    check("t3_lost",      32'(saw_lost), 32'd1);
    check("t3_lost_cnt",  32'(lock_lost_cnt), 32'd1);
    check("t3_then_wait", 32'(saw_wait), 32'd1);

    // Divider change requested mid-period takes effect on the next strobe.
    wait_run();
    div_val = 4'd3; div_req = 1'b1;
    for (int i = 0; i < 20 && !m_ack; i++) step();
    for (int i = 0; i < 20 && !clk_en; i++) step();
    step();
    div_val = 4'd1; div_req = 1'b1;
    for (int i = 0; i < 20 && !m_ack; i++) step();
    check("t4_ack",        32'(div_ack), 32'd1);
    check("t4_ack_strobe", 32'(clk_en), 32'd1);
    for (int k = 0; k < 3; k++) begin
      n = 0;
      do begin step(); n++; end while (!clk_en && n < 10);
      check("t4_period", 32'(n), 32'd2);
    end

    // Divider change outside RUN is acknowledged on the following cycle.
    do_reset(1'b0);
    repeat (3) step();
    div_val = 4'd2; div_req = 1'b1;
    step();
    check("t5_ack_wait", 32'(div_ack), 32'd1);
    pll_lock = 1'b1;
    wait_run();
    pat[5] = clk_en;
    for (int i = 4; i >= 0; i--) begin step(); pat[i] = clk_en; end
    check("t5_pattern", 32'(pat), 32'b100100);

    // Reset while a request is pending discards it.
    for (int i = 0; i < 10 && !clk_en; i++) step();
    step();
    div_val = 4'd5; div_req = 1'b1;
    step();
    rst = 1'b1; div_req = 1'b0;
    step();
    check("t6_state",   32'(state_o), 32'd0);
    check("t6_clk_en",  32'(clk_en), 32'd0);
    check("t6_div_ack", 32'(div_ack), 32'd0);
    rst = 1'b0;
    acks = 0;
    repeat (30) begin step(); if (div_ack) acks++; end
    check("t6_no_ack", 32'(acks), 32'd0);

    // Random lock bursts, glitches, divider requests and occasional resets.
    seg_left = 0; lock_v = 1'b1;
    for (int c = 0; c < 4000; c++) begin
      if (seg_left == 0) begin
        lock_v   = !lock_v;
        seg_left = lock_v ? int'($urandom_range(5, 60)) : int'($urandom_range(1, 7));
        pll_lock = lock_v;
      end
      seg_left--;
      if (!div_req && $urandom_range(0, 15) == 0) begin
        div_val = DIV_W'($urandom_range(0, 15));
        div_req = 1'b1;
      end
      rst = ($urandom_range(0, 799) == 0);
      if (rst) div_req = 1'b0;
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
